// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of a 5-stage pipeline.
// Holds the fetch PC, the IF/ID pipeline register, and saturating
// counters for stall and flush cycles. Every output is a register.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             PCwrite,
    input  logic             IF_IDwrite,
    input  logic             IF_flush,
    input  logic             branch,
    input  logic             jump,
    input  logic [31:0]      branch_target_i,
    input  logic [31:0]      jump_target_i,
    input  logic [31:0]      instr_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      IF_ID_pc_plus4_o,
    output logic [31:0]      IF_ID_instr_o,
    output logic             IF_ID_valid_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    logic [31:0]      r_pc;
    logic [31:0]      r_ifid_pc_plus4;
    logic [31:0]      r_ifid_instr;
    logic             r_ifid_valid;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic [31:0]      w_pc_plus4;
    logic [31:0]      w_next_pc;
    logic             w_stall_evt;

    // Sequential PC, wrapping naturally at 2^32.
    assign w_pc_plus4  = r_pc + 32'd4;

    // A flush takes precedence, so a simultaneous stall is not counted.
    assign w_stall_evt = !IF_IDwrite && !IF_flush;

    // Next-PC select: jump over branch, and any redirect overrides a PC hold.
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (jump) begin
            w_next_pc = {jump_target_i[31:2], 2'b00};
        end else if (branch) begin
            w_next_pc = {branch_target_i[31:2], 2'b00};
        end else if (!PCwrite) begin
            w_next_pc = r_pc;
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    // IF/ID pipeline register: flush inserts a bubble, otherwise capture or hold.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ifid_instr    <= '0;
            r_ifid_pc_plus4 <= '0;
            r_ifid_valid    <= 1'b0;
        end else if (IF_flush) begin
            r_ifid_instr    <= '0;
            r_ifid_pc_plus4 <= '0;
            r_ifid_valid    <= 1'b0;
        end else if (IF_IDwrite) begin
            r_ifid_instr    <= instr_i;
            r_ifid_pc_plus4 <= w_pc_plus4;
            r_ifid_valid    <= 1'b1;
        end
    end

    // Saturating stall and flush event counters.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (IF_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign pc_o             = r_pc;
    assign IF_ID_pc_plus4_o = r_ifid_pc_plus4;
    assign IF_ID_instr_o    = r_ifid_instr;
    assign IF_ID_valid_o    = r_ifid_valid;
    assign stall_cnt_o      = r_stall_cnt;
    assign flush_cnt_o      = r_flush_cnt;

endmodule
